// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared constants, action enum and stall decode for pipeline regs
// Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam logic c_stop    = 1'b1;
    localparam logic c_no_stop = 1'b0;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam int c_payload_w_def = 128;
    localparam int c_side_w_def    = 66;

    typedef enum logic [2:0] {
        ACT_RESET   = 3'd0,
        ACT_FLUSH   = 3'd1,
        ACT_BUBBLE  = 3'd2,
        ACT_CAPTURE = 3'd3,
        ACT_HOLD    = 3'd4
    } action_e;

    // First matching rule wins: reset, flush, bubble, capture, hold.
    function automatic action_e decode_action(
        input logic rst,
        input logic flush,
        input logic up,
        input logic dn
    );
        if (rst)                                return ACT_RESET;
        if (flush)                              return ACT_FLUSH;
        if (up == c_stop && dn == c_no_stop)    return ACT_BUBBLE;
        if (up == c_no_stop)                    return ACT_CAPTURE;
        return ACT_HOLD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg_if
// Brief    : Upstream/downstream payload, valid and side-state bundle
// Revision : 1.0  initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int PAYLOAD_W = 128,
    parameter int SIDE_W    = 66
);
    logic                 in_valid;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [SIDE_W-1:0]    in_side;
    logic                 out_valid;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [SIDE_W-1:0]    out_side;

    modport master (
        output in_valid, in_payload, in_side,
        input  out_valid, out_payload, out_side
    );

    modport slave (
        input  in_valid, in_payload, in_side,
        output out_valid, out_payload, out_side
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter with synchronous clear
// Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc,
    input  wire logic         clr,
    output logic [W-1:0]      count
);
    localparam logic [W-1:0] c_max = '1;

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && r_count != c_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Inter-stage pipeline register with bubble/hold/flush, perf
//            counters and a hold watchdog
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = c_payload_w_def,
    parameter int SIDE_W    = c_side_w_def,
    parameter int STALL_W   = 6,
    parameter int STAGE     = STG_EX,
    parameter int CNT_W     = 32,
    parameter int WDOG      = 1024
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [STALL_W-1:0] stall,
    input  wire logic               flush,
    input  wire logic               perf_clr,
    pipe_stage_reg_if.slave         bus,
    output logic [CNT_W-1:0]        cnt_hold,
    output logic [CNT_W-1:0]        cnt_bubble,
    output logic [CNT_W-1:0]        cnt_flush,
    output logic                    wdog_err
);
    generate
        if (STAGE + 1 >= STALL_W) begin : g_stage_check
            $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
        end
    endgenerate

    localparam int              RUN_W     = $clog2(WDOG + 2);
    localparam logic [RUN_W-1:0] c_run_max = RUN_W'(WDOG + 1);

    action_e                w_act;
    logic                   w_up;
    logic                   w_dn;
    logic [RUN_W-1:0]       w_run_nxt;
    logic                   w_unused_stall;

    logic                   r_valid;
    logic [PAYLOAD_W-1:0]   r_payload;
    logic [SIDE_W-1:0]      r_side;
    logic [RUN_W-1:0]       r_run;
    logic                   r_wdog_err;

    assign w_up           = stall[STAGE];
    assign w_dn           = stall[STAGE+1];
    assign w_unused_stall = ^stall;

    always_comb begin
        w_act     = decode_action(rst, flush, w_up, w_dn);
        w_run_nxt = '0;
        if (w_act == ACT_HOLD) begin
            w_run_nxt = (r_run == c_run_max) ? r_run : r_run + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        case (w_act)
            ACT_RESET, ACT_FLUSH: begin
                r_valid   <= 1'b0;
                r_payload <= '0;
                r_side    <= '0;
            end
            ACT_BUBBLE: begin
                // All-zero payload is the NOP encoding.
                r_valid   <= 1'b0;
                r_payload <= '0;
                r_side    <= bus.in_side;
            end
            ACT_CAPTURE: begin
                r_valid   <= bus.in_valid;
                r_payload <= bus.in_valid ? bus.in_payload : '0;
                r_side    <= '0;
            end
            default: begin
                r_side    <= bus.in_side;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        r_run <= w_run_nxt;
        if (rst || perf_clr) begin
            r_wdog_err <= 1'b0;
        end else if (w_run_nxt == c_run_max) begin
            r_wdog_err <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_hold (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_act == ACT_HOLD),
        .clr   (perf_clr),
        .count (cnt_hold)
    );

    sat_counter #(.W(CNT_W)) u_cnt_bubble (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_act == ACT_BUBBLE),
        .clr   (perf_clr),
        .count (cnt_bubble)
    );

    sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_act == ACT_FLUSH),
        .clr   (perf_clr),
        .count (cnt_flush)
    );

    assign bus.out_valid   = r_valid;
    assign bus.out_payload = r_payload;
    assign bus.out_side    = r_side;
    assign wdog_err        = r_wdog_err;
endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Directed self-checking bench for pipe_stage_reg (WDOG=4, CNT_W=3)
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;
    localparam int PW = 128;
    localparam int SW = 66;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          perf_clr;
    logic [CW-1:0] cnt_hold;
    logic [CW-1:0] cnt_bubble;
    logic [CW-1:0] cnt_flush;
    logic          wdog_err;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [5:0] c_run    = 6'b000000;
    localparam logic [5:0] c_bubble = 6'b001111;
    localparam logic [5:0] c_hold   = 6'b011111;

    logic [PW-1:0] pat_a5;
    logic [PW-1:0] pat_p;

    pipe_stage_reg_if #(.PAYLOAD_W(PW), .SIDE_W(SW)) bus ();

    pipe_stage_reg #(
        .PAYLOAD_W (PW),
        .SIDE_W    (SW),
        .STALL_W   (6),
        .STAGE     (3),
        .CNT_W     (CW),
        .WDOG      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .perf_clr   (perf_clr),
        .bus        (bus),
        .cnt_hold   (cnt_hold),
        .cnt_bubble (cnt_bubble),
        .cnt_flush  (cnt_flush),
        .wdog_err   (wdog_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pat_a5 = {16{8'hA5}};
        pat_p  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        rst = 1'b1; stall = c_run; flush = 1'b0; perf_clr = 1'b0;
        bus.in_valid = 1'b1; bus.in_payload = pat_a5; bus.in_side = 66'h3;
        step(); step();
        chk("rst_valid",  128'(bus.out_valid), 128'd0);
        chk("rst_payload", bus.out_payload, 128'd0);
        chk("rst_side",   128'(bus.out_side), 128'd0);
        chk("rst_cnts",   128'({cnt_hold, cnt_bubble, cnt_flush, wdog_err}), 128'd0);

        // Plain capture
        rst = 1'b0;
        step();
        chk("cap_valid",   128'(bus.out_valid), 128'd1);
        chk("cap_payload", bus.out_payload, pat_a5);
        chk("cap_side",    128'(bus.out_side), 128'd0);
        chk("cap_cnts",    128'({cnt_hold, cnt_bubble, cnt_flush}), 128'd0);

        // Bubbles carry side-state
        stall = c_bubble; bus.in_side = 66'h155;
        step();
        chk("bub1_valid",   128'(bus.out_valid), 128'd0);
        chk("bub1_payload", bus.out_payload, 128'd0);
        chk("bub1_side",    128'(bus.out_side), 128'h155);
        bus.in_side = 66'h2AA;
        step();
        chk("bub2_side",   128'(bus.out_side), 128'h2AA);
        chk("bub2_cnt",    128'(cnt_bubble), 128'd2);

        // Capture with in_valid=0 yields a zero payload
        stall = c_run; bus.in_valid = 1'b0; bus.in_payload = pat_a5;
        step();
        chk("capnv_valid",   128'(bus.out_valid), 128'd0);
        chk("capnv_payload", bus.out_payload, 128'd0);

        // Capture P then hold 3 cycles with changing inputs
        bus.in_valid = 1'b1; bus.in_payload = pat_p;
        step();
        chk("capp_payload", bus.out_payload, pat_p);
        stall = c_hold; bus.in_valid = 1'b0; bus.in_payload = pat_a5;
        for (int i = 1; i <= 3; i++) begin
            bus.in_side = 66'(i * 16 + 1);
            step();
            chk("hold_side", 128'(bus.out_side), 128'(i * 16 + 1));
        end
        chk("hold_payload", bus.out_payload, pat_p);
        chk("hold_valid",   128'(bus.out_valid), 128'd1);
        chk("hold_cnt",     128'(cnt_hold), 128'd3);
        chk("hold_wdog",    128'(wdog_err), 128'd0);

        // Flush beats a bubble pattern
        flush = 1'b1; stall = c_bubble; bus.in_side = 66'h3FF;
        step();
        flush = 1'b0;
        chk("fl_valid",  128'(bus.out_valid), 128'd0);
        chk("fl_side",   128'(bus.out_side), 128'd0);
        chk("fl_cnt",    128'(cnt_flush), 128'd1);
        chk("fl_bubble", 128'(cnt_bubble), 128'd2);

        // Watchdog: 5 consecutive holds trip WDOG=4
        stall = c_hold;
        for (int i = 1; i <= 4; i++) step();
        chk("wd_4", 128'(wdog_err), 128'd0);
        step();
        chk("wd_5", 128'(wdog_err), 128'd1);
        chk("hold_sat", 128'(cnt_hold), 128'd7);
        stall = c_run;
        step();
        chk("wd_sticky", 128'(wdog_err), 128'd1);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        chk("clr_wdog", 128'(wdog_err), 128'd0);
        chk("clr_cnts", 128'({cnt_hold, cnt_bubble, cnt_flush}), 128'd0);

        // Bubble counter saturation, then clear beats increment
        stall = c_bubble;
        for (int i = 1; i <= 7; i++) step();
        chk("bub_7", 128'(cnt_bubble), 128'd7);
        step(); step();
        chk("bub_sat", 128'(cnt_bubble), 128'd7);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        chk("bub_clr", 128'(cnt_bubble), 128'd0);

        // Reset in the middle of a hold wipes everything
        stall = c_run; bus.in_valid = 1'b1; bus.in_payload = pat_p;
        step();
        stall = c_hold; bus.in_side = 66'h1;
        step(); step();
        chk("pre_rst_cnt", 128'(cnt_hold), 128'd2);
        rst = 1'b1;
        step();
        rst = 1'b0; stall = c_run; bus.in_valid = 1'b0;
        chk("midrst_valid",   128'(bus.out_valid), 128'd0);
        chk("midrst_payload", bus.out_payload, 128'd0);
        chk("midrst_side",    128'(bus.out_side), 128'd0);
        chk("midrst_cnt",     128'(cnt_hold), 128'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage core, replacing per-stage hand-written registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It captures a flat payload bus and a valid bit, decodes the global stall vector for its own stage, and inserts a bubble, holds, or captures. It also carries a multi-cycle side-state bus (HI/LO accumulator plus step count) across stalls and supports exception flush. Saturating performance counters and a stall watchdog support debug.

## Interface
Parameters:
- PAYLOAD_W, 128: width of the forwarded payload bus.
- SIDE_W, 66: width of the multi-cycle side-state bus (64-bit accumulator plus 2-bit count).
- STALL_W, 6: width of the global stall vector.
- STAGE, 3: index of the upstream stage in the stall vector. STAGE+1 < STALL_W is an elaboration-time error check.
- CNT_W, 32: performance counter width.
- WDOG, 1024: consecutive hold cycles allowed before the watchdog flags.

Ports (clock and reset first):
- clk  in  1  clock. Reset rst is synchronous, active-high; clock clk.
- rst  in  1  synchronous active-high reset.
- stall  in  STALL_W  global stall vector; 1 = Stop.
- flush  in  1  exception flush; kills the register contents.
- in_valid  in  1  upstream instruction valid.
- in_payload  in  PAYLOAD_W  upstream payload.
- in_side  in  SIDE_W  side-state from the upstream multi-cycle unit.
- perf_clr  in  1  clears the counters and the watchdog flag.
- out_valid  out  1  registered valid.
- out_payload  out  PAYLOAD_W  registered payload.
- out_side  out  SIDE_W  registered side-state, fed back upstream.
- cnt_hold  out  CNT_W  cycles spent in HOLD.
- cnt_bubble  out  CNT_W  bubbles inserted.
- cnt_flush  out  CNT_W  flushes taken.
- wdog_err  out  1  sticky flag: HOLD lasted more than WDOG consecutive cycles.

## Operation
- Define up = stall[STAGE] and dn = stall[STAGE+1].
- The action is chosen each cycle by the first matching rule below (priority order):
  - RESET (rst): every output 0, including the counters, wdog_err and the internal run length.
  - FLUSH (flush): out_valid=0, out_payload=0, out_side=0; cnt_flush increments. This aborts any in-flight multi-cycle operation.
  - BUBBLE (up=1, dn=0): out_valid=0, out_payload=0 (the all-zero payload is the NOP encoding), out_side<=in_side; cnt_bubble increments.
  - CAPTURE (up=0): out_valid<=in_valid. out_payload<=in_payload when in_valid is 1, otherwise 0. out_side<=0.
  - HOLD (up=1, dn=1): out_valid and out_payload keep their values, out_side<=in_side; cnt_hold increments.
- Watchdog:
  - An internal run length counts consecutive HOLD cycles, saturating at WDOG+1, and resets to 0 on any non-HOLD cycle.
  - wdog_err sets when the run length reaches WDOG+1 and stays set until rst or perf_clr.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- perf_clr zeroes all three counters and wdog_err. It takes precedence over an increment in the same cycle. It does not affect the payload path or the run length.

## Timing
- Latency is one cycle from in_* to out_*. There is no combinational path from inputs to outputs.
- out_side is valid the cycle after BUBBLE or HOLD, which lets a two-cycle MADD/MSUB loop back through the register.
- flush in the same cycle as any stall pattern: FLUSH wins.
- rst asserted mid-HOLD or mid-multi-cycle operation: everything is 0 on the next edge and side-state is lost.
- Stall rising and falling on consecutive cycles: each cycle is decoded independently. There is no stall hysteresis.
- A counter at saturation in the same cycle as perf_clr goes to 0.

## Structure
- Shared package pipe_pkg holds:
  - the Stop/NoStop constants;
  - stall-index constants (STG_PC=0 through STG_WB=5);
  - the action enum {ACT_RESET, ACT_FLUSH, ACT_BUBBLE, ACT_CAPTURE, ACT_HOLD};
  - the default payload and side widths.
- Sub-module sat_counter (parameter W; ports inc, clr; output count) is instantiated three times.
- The action decode is a single combinational function returning the enum.

## Test plan
- Reset, then stall=0, in_valid=1, in_payload=0xA5…A5 → next cycle out_valid=1 and out_payload=0xA5…A5; out_side=0; all counters 0.
- STAGE=3, stall=6'b001111 for 2 cycles with in_side=0x155 then 0x2AA → out_valid=0, out_payload=0; out_side follows 0x155 then 0x2AA; cnt_bubble=2.
- Capture payload P, then stall=6'b011111 for 3 cycles → out_payload stays P and out_valid stays 1; cnt_hold=3; out_side follows in_side.
- flush=1 together with stall=6'b001111 → out_valid=0, out_side=0, cnt_flush=1, cnt_bubble unchanged.
- WDOG=4, HOLD for 5 cycles → wdog_err=0 after the 4th hold edge and 1 after the 5th. A capture cycle then leaves wdog_err=1. perf_clr=1 → wdog_err=0 and all counters 0.
- CNT_W=3, 9 bubbles → cnt_bubble saturates at 7. Then perf_clr together with a bubble → cnt_bubble=0.
